// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order write queue in front of the register file's single write port,
// with two youngest-match bypass lookups that mirror the file's read ports.
`default_nettype none

module regfile_writeback #(
  parameter int DEPTH     = 4,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter bit DROP_ZERO = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     rf_stall,
  output logic                     rf_write,
  output logic [AW-1:0]            rf_write_addr,
  output logic [DW-1:0]            rf_write_data,
  input  logic [AW-1:0]            lookup_addr1,
  input  logic [AW-1:0]            lookup_addr2,
  output logic                     lookup_hit1,
  output logic                     lookup_hit2,
  output logic [DW-1:0]            lookup_data1,
  output logic [DW-1:0]            lookup_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic push, store, pop;

  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // Dropped address-0 writes still complete the handshake, they just never occupy a slot.
  assign store    = push && !(DROP_ZERO && (in_addr == '0));
  assign rf_write = !empty && !rf_stall;
  assign pop      = rf_write;

  assign rf_write_addr = empty ? '0 : addr_q[rd_ptr_q];
  assign rf_write_data = empty ? '0 : data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (store) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
    case ({store, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so the last match wins; the head entry is still valid this cycle.
  always_comb begin
    logic [PW-1:0] idx;
    lookup_hit1  = 1'b0;
    lookup_hit2  = 1'b0;
    lookup_data1 = '0;
    lookup_data2 = '0;
    idx          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (addr_q[idx] == lookup_addr1) begin
          lookup_hit1  = 1'b1;
          lookup_data1 = data_q[idx];
        end
        if (addr_q[idx] == lookup_addr2) begin
          lookup_hit2  = 1'b1;
          lookup_data2 = data_q[idx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (store) begin
        addr_q[wr_ptr_q] <= in_addr;
        data_q[wr_ptr_q] <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: directed pushes queue expected writes, a negedge
// monitor pops and compares every register-file write.
`default_nettype none

module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, rf_stall = 1'b0;
  logic [4:0]  in_addr = '0, lookup_addr1 = '0, lookup_addr2 = '0;
  logic [31:0] in_data = '0;
  logic        in_ready, rf_write, lookup_hit1, lookup_hit2, empty;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data, lookup_data1, lookup_data2;
  logic [2:0]  count;

  logic        dz_in_valid = 1'b0, dz_rf_stall = 1'b0;
  logic [4:0]  dz_in_addr = '0, dz_lookup_addr1 = '0, dz_lookup_addr2 = '0;
  logic [31:0] dz_in_data = '0;
  logic        dz_in_ready, dz_rf_write, dz_hit1, dz_hit2, dz_empty;
  logic [4:0]  dz_rf_write_addr;
  logic [31:0] dz_rf_write_data, dz_data1, dz_data2;
  logic [2:0]  dz_count;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } exp_t;
  exp_t sbq[$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  regfile_writeback #(.DEPTH(4), .AW(5), .DW(32), .DROP_ZERO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .rf_stall(rf_stall), .rf_write(rf_write),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .lookup_addr1(lookup_addr1), .lookup_addr2(lookup_addr2),
    .lookup_hit1(lookup_hit1), .lookup_hit2(lookup_hit2),
    .lookup_data1(lookup_data1), .lookup_data2(lookup_data2),
    .count(count), .empty(empty));

  regfile_writeback #(.DEPTH(4), .AW(5), .DW(32), .DROP_ZERO(1'b1)) u_dz (
    .clk(clk), .rst_n(rst_n), .in_valid(dz_in_valid), .in_ready(dz_in_ready),
    .in_addr(dz_in_addr), .in_data(dz_in_data), .rf_stall(dz_rf_stall), .rf_write(dz_rf_write),
    .rf_write_addr(dz_rf_write_addr), .rf_write_data(dz_rf_write_data),
    .lookup_addr1(dz_lookup_addr1), .lookup_addr2(dz_lookup_addr2),
    .lookup_hit1(dz_hit1), .lookup_hit2(dz_hit2),
    .lookup_data1(dz_data1), .lookup_data2(dz_data2),
    .count(dz_count), .empty(dz_empty));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write presented to the register file must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rf_write) begin
      if (sbq.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("wr_addr", 32'(rf_write_addr), 32'(e.a));
        chk("wr_data", rf_write_data, e.d);
      end
    end
  end

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    bit acc;
    int n;
    in_valid = 1'b1; in_addr = a; in_data = d;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (acc) sbq.push_back('{a: a, d: d});
    else     chk("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    @(negedge clk);
    while (!empty && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!empty) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_write", 32'(rf_write), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single write with bypass
    lookup_addr1 = 5'd5;
    push(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_write", 32'(rf_write), 32'd1);
    chk("single_hit1", 32'(lookup_hit1), 32'd1);
    chk("single_data1", lookup_data1, 32'hDEADBEEF);
    chk("single_count", 32'(count), 32'd1);
    @(negedge clk);
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_hit1_gone", 32'(lookup_hit1), 32'd0);
    chk("single_data1_gone", lookup_data1, 32'd0);
    @(posedge clk); #1;

    // Full queue and backpressure
    rf_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 'h11));
    @(negedge clk);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_stalled", 32'(rf_write), 32'd0);
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'h55;
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_holdoff", 32'(count), 32'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rf_stall = 1'b0;
    @(negedge clk);
    chk("unstall_write", 32'(rf_write), 32'd1);
    chk("unstall_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("pop1_ready", 32'(in_ready), 32'd1);
    chk("pop1_count", 32'(count), 32'd3);
    chk("pop1_write", 32'(rf_write), 32'd1);
    @(negedge clk);
    chk("pop2_write", 32'(rf_write), 32'd1);
    @(negedge clk);
    chk("pop3_write", 32'(rf_write), 32'd1);
    wait_empty();

    // Youngest match
    rf_stall = 1'b1;
    lookup_addr2 = 5'd7;
    push(5'd7, 32'hA);
    push(5'd7, 32'hB);
    @(negedge clk);
    chk("young_hit", 32'(lookup_hit2), 32'd1);
    chk("young_data", lookup_data2, 32'hB);
    @(posedge clk); #1;
    rf_stall = 1'b0;
    @(negedge clk);
    chk("young_w1_data", rf_write_data, 32'hA);
    chk("young_w1_lookup", lookup_data2, 32'hB);
    @(negedge clk);
    chk("young_w2_data", rf_write_data, 32'hB);
    chk("young_w2_hit", 32'(lookup_hit2), 32'd1);
    @(negedge clk);
    chk("young_done_hit", 32'(lookup_hit2), 32'd0);
    chk("young_done_data", lookup_data2, 32'd0);
    @(posedge clk); #1;

    // Back-to-back stream: one push and one write per cycle through wrapping pointers
    lookup_addr1 = 5'd12;
    for (int i = 0; i < 8; i++) begin
      push(5'(8 + i), 32'h1000 + 32'(i));
      @(negedge clk);
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_write", 32'(rf_write), 32'd1);
      if (i == 4) chk("stream_bypass", lookup_data1, 32'h1004);
    end
    wait_empty();

    // Asynchronous reset with pending entries
    rf_stall = 1'b1;
    lookup_addr1 = 5'd3;
    push(5'd2, 32'h22); push(5'd3, 32'h33); push(5'd4, 32'h44);
    rf_stall = 1'b0;
    #1 rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("arst_write", 32'(rf_write), 32'd0);
    chk("arst_waddr", 32'(rf_write_addr), 32'd0);
    chk("arst_wdata", rf_write_data, 32'd0);
    chk("arst_hit1", 32'(lookup_hit1), 32'd0);
    chk("arst_data1", lookup_data1, 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_ready", 32'(in_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(rf_write), 32'd0);
    end
    @(posedge clk); #1;

    // Dropped address-0 writes
    dz_lookup_addr1 = 5'd0;
    dz_in_valid = 1'b1; dz_in_addr = 5'd0; dz_in_data = 32'h1234;
    chk("dz_ready", 32'(dz_in_ready), 32'd1);
    @(posedge clk); #1;
    dz_in_valid = 1'b0;
    @(negedge clk);
    chk("dz_count", 32'(dz_count), 32'd0);
    chk("dz_empty", 32'(dz_empty), 32'd1);
    chk("dz_write", 32'(dz_rf_write), 32'd0);
    chk("dz_hit", 32'(dz_hit1), 32'd0);
    @(posedge clk); #1;
    dz_rf_stall = 1'b1; dz_lookup_addr2 = 5'd3;
    dz_in_valid = 1'b1; dz_in_addr = 5'd3; dz_in_data = 32'h33;
    @(posedge clk); #1;
    dz_in_valid = 1'b0;
    @(negedge clk);
    chk("dz_nonzero_count", 32'(dz_count), 32'd1);
    chk("dz_nonzero_hit", 32'(dz_hit2), 32'd1);
    chk("dz_nonzero_data", dz_data2, 32'h33);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
